// File: rtl/rca_pkg.sv
// Shared types and constants for the sequential slice-by-slice ripple-carry adder.
package rca_pkg;
  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the ripple slice.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/rca_slice4.sv
// Combinational SLICE_W-bit ripple-carry slice: a chain of full_adder cells.
module rca_slice4
  import rca_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               c_in,
  output logic [SLICE_W-1:0] sum,
  output logic               c_out
);
  logic [SLICE_W:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign c_out = c[SLICE_W];
endmodule

// File: rtl/rca_seq_adder.sv
// Sequential W-bit adder reusing one 4-bit ripple slice, one slice per cycle.
// Optional signed-overflow output is enabled by defining RCA_SEQ_OVF_EN.
module rca_seq_adder
  import rca_pkg::*;
#(
  parameter int  NSLICES = 4,
  localparam int W       = SLICE_W * NSLICES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         c_out,
`ifdef RCA_SEQ_OVF_EN
  output logic         ovf,
`endif
  output logic         busy
);
  localparam int IDX_W = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
`ifdef RCA_SEQ_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [SLICE_W-1:0] sl_a, sl_b, sl_s;
  logic               sl_co;

  // Select the active operand slice by idx.
  always_comb begin
    sl_a = '0;
    sl_b = '0;
    for (int i = 0; i < NSLICES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sl_a = a_q[i*SLICE_W +: SLICE_W];
        sl_b = b_q[i*SLICE_W +: SLICE_W];
      end
    end
  end

  rca_slice4 u_slice (
    .a     (sl_a),
    .b     (sl_b),
    .c_in  (carry_q),
    .sum   (sl_s),
    .c_out (sl_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef RCA_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        for (int i = 0; i < NSLICES; i++) begin
          if (idx_q == IDX_W'(i)) sum_d[i*SLICE_W +: SLICE_W] = sl_s;
        end
        carry_d = sl_co;
        if (idx_q == LAST_IDX) begin
          // idx parks on the last slice so it never runs past NSLICES-1
          cout_d  = sl_co;
`ifdef RCA_SEQ_OVF_EN
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (sl_s[SLICE_W-1] != a_q[W-1]);
`endif
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef RCA_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC);
  assign sum       = sum_q;
  assign c_out     = cout_q;
`ifdef RCA_SEQ_OVF_EN
  assign ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_rca_seq_adder.sv
// Directed bench for rca_seq_adder (NSLICES=4, W=16); checks ovf when RCA_SEQ_OVF_EN is defined.
module tb_rca_seq_adder;
  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, sum;
  logic        c_in, c_out, busy;
`ifdef RCA_SEQ_OVF_EN
  logic        ovf;
`endif

  int n_chk = 0;
  int n_err = 0;

  rca_seq_adder #(.NSLICES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
`ifdef RCA_SEQ_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for out_valid; called at the negedge of the first CALC cycle.
  task automatic wait_done(output int cnt);
    cnt = 1;
    while (!out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                        input logic [15:0] es, input logic ec, input logic eovf,
                        input string tag);
    int cnt;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = ta; b = tb_v; c_in = tc; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(cnt);
    chk({tag, "_latency"}, 32'(cnt), 32'd5);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_c_out"}, 32'(c_out), 32'(ec));
`ifdef RCA_SEQ_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(eovf));
`else
    if (eovf === 1'bx) n_chk = n_chk + 0;
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_back_idle"}, 32'(in_ready), 32'd1);
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int cnt;
    int nres;
    int last;
    logic seen;
    logic [16:0] q[$];
    logic [16:0] e;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_c_out", 32'(c_out), 32'd0);

    run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, "one_plus_one");
    run_op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, "ripple_all");
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "signed_ovf");
    run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "neg_ovf");
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "no_ovf_mixed");

    // Backpressure: result held while out_ready low, new in_valid ignored
    a = 16'h1234; b = 16'h4321; c_in = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 16'hAAAA; b = 16'h1111;
    wait_done(cnt);
    chk("hold_latency", 32'(cnt), 32'd5);
    for (int i = 0; i < 10; i++) begin
      chk("hold_sum", 32'(sum), 32'h5555);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("drain_in_ready", 32'(in_ready), 32'd1);
    chk("drain_busy", 32'(busy), 32'd0);
    chk("drain_sum", 32'(sum), 32'h5555);
    @(negedge clk);
    in_valid = 1'b0;
    chk("after_drain_accept", 32'(busy), 32'd1);
    wait_done(cnt);
    chk("after_drain_latency", 32'(cnt), 32'd5);
    chk("after_drain_sum", 32'(sum), 32'hBBBB);
    chk("after_drain_c_out", 32'(c_out), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Abort on the second CALC cycle
    a = 16'h0005; b = 16'h0006; c_in = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_calc", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_c_out", 32'(c_out), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen = seen | out_valid;
      @(negedge clk);
    end
    chk("abort_no_valid", 32'(seen), 32'd0);
    run_op(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, "post_abort");

    // Back-to-back with in_valid and out_ready tied high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom);
    nres = 0;
    last = -1;
    for (int cyc = 0; cyc < 200 && nres < 8; cyc++) begin
      if (out_valid) begin
        if (q.size() > 0) e = q.pop_front();
        else e = 17'h1FFFF;
        chk("b2b_sum", 32'(sum), 32'(e[15:0]));
        chk("b2b_c_out", 32'(c_out), 32'(e[16]));
        if (last >= 0) chk("b2b_period", 32'(cyc - last), 32'd6);
        last = cyc;
        nres++;
      end
      if (in_ready) begin
        q.push_back({1'b0, a} + {1'b0, b} + {16'd0, c_in});
      end else begin
        a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom);
      end
      @(negedge clk);
    end
    chk("b2b_count", 32'(nres), 32'd8);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
